// File: rtl/gcd_pkg.sv
// Shared GCD sequencer types: default operand width and the sequencer state encoding.
// Latency: none (package only).
// Backpressure: n/a.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_HOLD
  } gcd_state_e;

  // States in which the downstream engine sees an active start.
  function automatic logic engine_busy(input gcd_state_e s);
    return (s == S_LOAD_A) || (s == S_LOAD_B) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/gcd_timeout_ctr.sv
// WAIT-cycle watchdog: counts enabled cycles from 0, flags the TIMEOUT-th one.
// Latency: expired is combinational on the cycle the count reaches TIMEOUT.
// Backpressure: none; clear has priority over enable.
module gcd_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = enable && !clear && (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Feeds operand pairs serially to a GCD engine and holds its result; GCD_TIMEOUT_EN adds a WAIT watchdog.
// Latency: accept->out_valid 3+k cycles (k WAIT cycles), 1 cycle when an operand is zero.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH   = GCD_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
  logic             out_err_d;
  logic             timeout_expired;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out_gcd   = out_gcd_q;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    out_gcd_d = out_gcd_q;
    out_err_d = out_err;
    gcd_start = engine_busy(state_q);
    gcd_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // gcd(x,0)=x and gcd(0,0)=0, so a zero operand never reaches the engine.
          if ((in_a == '0) || (in_b == '0)) begin
            out_gcd_d = in_a | in_b;
            out_err_d = 1'b0;
            state_d   = S_HOLD;
          end else begin
            op_a_d  = in_a;
            op_b_d  = in_b;
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: begin
        gcd_data = op_a_q;
        state_d  = S_LOAD_B;
      end
      S_LOAD_B: begin
        gcd_data = op_b_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        gcd_data = op_b_q;
        if (gcd_done) begin
          out_gcd_d = gcd_result;
          out_err_d = 1'b0;
          state_d   = S_HOLD;
        end else if (timeout_expired) begin
          out_gcd_d = '0;
          out_err_d = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      out_gcd_q <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      out_gcd_q <= out_gcd_d;
    end
  end

`ifdef GCD_TIMEOUT_EN
  logic out_err_q;

  gcd_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != S_WAIT),
    .enable  (state_q == S_WAIT),
    .expired (timeout_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err_q <= 1'b0;
    end else begin
      out_err_q <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  // No watchdog: WAIT lasts until gcd_done and the error flag cannot be set.
  logic unused_cfg;
  assign timeout_expired = 1'b0;
  assign out_err         = 1'b0;
  assign unused_cfg      = out_err_d ^ (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer with a cycle-exact downstream GCD model and result scoreboard.
module tb_gcd_operand_sequencer;

`ifdef GCD_TIMEOUT_EN
  localparam int unsigned TO = 20;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        gcd_start;
  logic [15:0] gcd_data;
  logic        gcd_done;
  logic [15:0] gcd_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_gcd;
  logic        out_err;

  typedef struct {
    logic [15:0] g;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  gcd_operand_sequencer #(
    .WIDTH   (16),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .gcd_start  (gcd_start),
    .gcd_data   (gcd_data),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] gcd_fn(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offers a pair at the current negedge and plays the GCD engine for k WAIT cycles.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input int k,
                          input bit done, input logic [15:0] exp_g, input logic exp_e,
                          input string tag);
    exp_t ex;
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    ex.g = exp_g;
    ex.e = exp_e;
    sb.push_back(ex);
    @(negedge clk);
    in_valid = 1'b0;
    if ((a == 0) || (b == 0)) begin
      chk({tag, ".bypass_start"}, gcd_start, 0);
      chk({tag, ".bypass_valid"}, out_valid, 1);
    end else begin
      chk({tag, ".load_a_start"}, gcd_start, 1);
      chk({tag, ".load_a_data"}, gcd_data, a);
      chk({tag, ".load_a_valid"}, out_valid, 0);
      @(negedge clk);
      chk({tag, ".load_b_start"}, gcd_start, 1);
      chk({tag, ".load_b_data"}, gcd_data, b);
      for (int i = 1; i <= k; i++) begin
        @(negedge clk);
        chk({tag, ".wait_valid"}, out_valid, 0);
        chk({tag, ".wait_start"}, gcd_start, 1);
        if (done && (i == k)) begin
          gcd_done   = 1'b1;
          gcd_result = gcd_fn(a, b);
        end
      end
      @(negedge clk);
      gcd_done   = 1'b0;
      gcd_result = 16'd0;
      chk({tag, ".latency_valid"}, out_valid, 1);
      chk({tag, ".hold_start"}, gcd_start, 0);
    end
  endtask

  // Stalls the consumer for 'hold' cycles (with stray done pulses), then takes the result.
  task automatic take_result(input int hold, input string tag);
    exp_t ex;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
      return;
    end
    ex = sb.pop_front();
    for (int j = 0; j < hold; j++) begin
      chk({tag, ".stall_valid"}, out_valid, 1);
      chk({tag, ".stall_gcd"}, out_gcd, ex.g);
      chk({tag, ".stall_in_ready"}, in_ready, 0);
      gcd_done   = j[0];
      gcd_result = 16'hBEEF;
      @(negedge clk);
    end
    gcd_done   = 1'b0;
    gcd_result = 16'd0;
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".out_gcd"}, out_gcd, ex.g);
    chk({tag, ".out_err"}, out_err, ex.e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, out_valid, 0);
    chk({tag, ".post_in_ready"}, in_ready, 1);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = 16'd0;
    in_b       = 16'd0;
    gcd_done   = 1'b0;
    gcd_result = 16'd0;
    out_ready  = 1'b0;

    #3;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.gcd_start", gcd_start, 0);
    chk("rst.gcd_data", gcd_data, 0);
    chk("rst.out_gcd", out_gcd, 0);
    chk("rst.out_err", out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1);

    run_pair(16'd143, 16'd78, 6, 1'b1, 16'd13, 1'b0, "p143_78");
    take_result(0, "p143_78");

    run_pair(16'd0, 16'd42, 0, 1'b0, 16'd42, 1'b0, "p0_42");
    take_result(0, "p0_42");
    run_pair(16'd0, 16'd0, 0, 1'b0, 16'd0, 1'b0, "p0_0");
    take_result(0, "p0_0");

    run_pair(16'd100, 16'd75, 2, 1'b1, 16'd25, 1'b0, "stall");
    take_result(10, "stall");

    // Abort an operation two cycles into WAIT; out_gcd still holds 25 from before.
    in_valid = 1'b1;
    in_a     = 16'd50;
    in_b     = 16'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.wait_start", gcd_start, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.rst_start", gcd_start, 0);
    chk("mid.rst_data", gcd_data, 0);
    chk("mid.rst_valid", out_valid, 0);
    chk("mid.rst_gcd", out_gcd, 0);
    chk("mid.rst_err", out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      gcd_done   = 1'b1;
      gcd_result = 16'd10;
      @(negedge clk);
      chk("mid.no_valid", out_valid, 0);
    end
    gcd_done   = 1'b0;
    gcd_result = 16'd0;
    run_pair(16'd40, 16'd64, 3, 1'b1, 16'd8, 1'b0, "after_rst");
    take_result(0, "after_rst");

    run_pair(16'd24, 16'd36, 4, 1'b1, 16'd12, 1'b0, "b2b_1");
    take_result(0, "b2b_1");
    run_pair(16'd17, 16'd5, 2, 1'b1, 16'd1, 1'b0, "b2b_2");
    take_result(0, "b2b_2");

`ifdef GCD_TIMEOUT_EN
    run_pair(16'd9, 16'd6, 20, 1'b0, 16'd0, 1'b1, "timeout");
    take_result(0, "timeout");
    run_pair(16'd9, 16'd6, 20, 1'b1, 16'd3, 1'b0, "done_wins");
    take_result(0, "done_wins");
`endif

    chk("sb.drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcd_operand_sequencer.md
GCD_OPERAND_SEQUENCER -- requirements
Module: gcd_operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 255: max WAIT cycles before abort (used only with GCD_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1: pair accepted when in_valid&&in_ready.
REQ-007 SHALL have ports in_a and in_b, input, WIDTH: operands.
REQ-008 SHALL have port gcd_start, output, 1: start to downstream GCD controller.
REQ-009 SHALL have port gcd_data, output, WIDTH: serial operand bus to GCD datapath data_in.
REQ-010 SHALL have port gcd_done, input, 1: completion from GCD controller.
REQ-011 SHALL have port gcd_result, input, WIDTH: GCD datapath A-register value.
REQ-012 SHALL have port out_valid, output, 1: result available.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-014 SHALL have port out_gcd, output, WIDTH: captured result.
REQ-015 SHALL have port out_err, output, 1: timeout abort flag (constant 0 without GCD_TIMEOUT_EN).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, WAIT, HOLD.
REQ-017 SHALL drive in_ready=1 only in IDLE.
REQ-018 SHALL, on handshake in IDLE with in_a!=0 and in_b!=0, register both operands and go to LOAD_A next cycle.
REQ-019 SHALL, in LOAD_A, drive gcd_data=A, gcd_start=1; next state LOAD_B unconditionally.
REQ-020 SHALL, in LOAD_B, drive gcd_data=B, gcd_start=1; next state WAIT unconditionally.
REQ-021 SHALL hold gcd_start=1 in WAIT; gcd_start=0 in IDLE and HOLD; gcd_data=B in WAIT, 0 in IDLE/HOLD.
REQ-022 SHALL sample gcd_done only in WAIT; gcd_done in any other state is ignored.
REQ-023 SHALL, on gcd_done=1 in WAIT, capture gcd_result into out_gcd, clear out_err, enter HOLD.
REQ-024 SHALL, on handshake with in_a==0 or in_b==0, bypass the engine: out_gcd=in_a|in_b (gcd(0,0)=0), out_err=0, next state HOLD directly.
REQ-025 SHALL assert out_valid exactly in HOLD, with out_gcd/out_err stable until out_ready.
REQ-026 SHALL, on out_ready=1 in HOLD, go to IDLE next cycle; earliest new acceptance one cycle after result handshake.
REQ-027 SHALL give latency accept->out_valid of 3+k cycles, k = cycles in WAIT until gcd_done (k>=1); 1 cycle for bypass.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-operation, asynchronously force IDLE, in_ready=1 after release, gcd_start=0, gcd_data=0, out_valid=0, out_gcd=0, out_err=0, timeout counter=0.
REQ-029 SHALL discard any in-flight operation on reset; no result is emitted for it.

Configuration
REQ-030 SHALL, with GCD_TIMEOUT_EN defined, count WAIT cycles from 0; when count reaches TIMEOUT without gcd_done, enter HOLD with out_gcd=0, out_err=1.
REQ-031 SHALL, if gcd_done and timeout coincide in one cycle, treat it as done (done wins).
REQ-032 SHALL, without GCD_TIMEOUT_EN, contain no counter, wait indefinitely in WAIT, tie out_err to 0.

Structure
REQ-033 SHALL place the default WIDTH constant and the state enumeration typedef in shared package gcd_pkg.
REQ-034 SHALL implement the watchdog as sub-module gcd_timeout_ctr (clear, enable, expired), instantiated only under GCD_TIMEOUT_EN.

Verification
REQ-035 SHALL cover: in_a=143,in_b=78, model asserts done after 6 WAIT cycles with result 13 -> gcd_data 143 then 78, out_valid 9 cycles after accept, out_gcd=13, out_err=0.
REQ-036 SHALL cover: in_a=0,in_b=42 -> gcd_start never asserted, out_valid next cycle, out_gcd=42; in_a=0,in_b=0 -> out_gcd=0.
REQ-037 SHALL cover: out_ready held low 10 cycles in HOLD -> out_valid/out_gcd stable, in_ready=0 throughout, gcd_done pulses ignored.
REQ-038 SHALL cover: rst_n pulsed low in WAIT -> all outputs reset immediately, no out_valid afterwards, next pair processed normally.
REQ-039 SHALL cover (GCD_TIMEOUT_EN, TIMEOUT=20): gcd_done never asserted -> out_valid after 20 WAIT cycles, out_err=1, out_gcd=0; done on cycle 20 -> out_err=0.
REQ-040 SHALL cover: back-to-back pairs (24,36) then (17,5) with out_ready=1 -> results 12 then 1, second accept one cycle after first result handshake.
